mem_arbiter: RTL and testbench

Single-port memory arbiter that lets the core's instruction-fetch path and data-access path share one unified synchronous memory. It sits between the core's fetch/load-store requesters and the memory macro. It serialises requests with a one-outstanding request/ack handshake and applies round-robin arbitration under contention. The core stalls on each requester until its ack pulse arrives.

---
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port memory between the fetch
// and data requesters. Requests are served one at a time, and contention is
// resolved round-robin.
//
// Ports:
//   clock_i, reset_n_i            clock, synchronous active-low reset
//   if_req_i/if_addr_i            fetch request and address
//   if_ack_o/if_rdata_o           fetch done pulse, fetched word (held)
//   dm_req_i/dm_we_i/dm_addr_i/
//   dm_wdata_i                    data request, write flag, address, write data
//   dm_ack_o/dm_rdata_o           data done pulse, read word (held)
//   mem_en_o/mem_we_o/mem_addr_o/
//   mem_wdata_o/mem_rdata_i       memory macro side
//   busy_o/grant_o                transaction in progress, owner (0 fetch, 1 data)
module mem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              grant_o
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_ack_d     = 1'b0;
    dm_ack_d     = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (if_req_i || dm_req_i) begin
          // Under contention the requester that did not win last time goes next
          grant_d      = (if_req_i && dm_req_i) ? ~last_grant_q : dm_req_i;
          last_grant_d = grant_d;
          we_d         = grant_d & dm_we_i;
          mem_en_d     = 1'b1;
          mem_we_d     = grant_d & dm_we_i;
          mem_addr_d   = grant_d ? dm_addr_i : if_addr_i;
          mem_wdata_d  = grant_d ? dm_wdata_i : '0;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          // Read data is valid only on this cycle; writes capture nothing
          if (!grant_q) begin
            if_rdata_d = mem_rdata_i;
          end else if (!we_q) begin
            dm_rdata_d = mem_rdata_i;
          end
          if_ack_d = ~grant_q;
          dm_ack_d = grant_q;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      if_ack_q     <= if_ack_d;
      dm_ack_q     <= dm_ack_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign if_ack_o    = if_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_ack_o    = dm_ack_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = busy_q;
  assign grant_o     = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (memory latency 1 and 3) run the same
// scenario side by side against a transaction-level reference and memory model.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef struct {
    int unsigned   cyc;
    bit            owner;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  logic        clk = 1'b0;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [AW-1:0] pool_addr();
    return AW'(32'h1000 + ($urandom_range(0, 7) << 2));
  endfunction

  function automatic void chk(input string name, input int inst,
                              input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got 0x%0h expected 0x%0h", name, inst, cyc, act, exp);
    end
  endfunction

  function automatic void fail_timeout(input string name, input int inst);
    checks++;
    errors++;
    $display("FAIL %s inst%0d cycle %0d: got no response expected one within bound", name, inst, cyc);
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int unsigned L    = (gi == 0) ? 1 : 3;
    localparam int unsigned ROFF = (L > 2) ? 3 : 2;

    logic          rst_n    = 1'b0;
    logic          if_req   = 1'b0;
    logic [AW-1:0] if_addr  = '0;
    logic          dm_req   = 1'b0;
    logic          dm_we    = 1'b0;
    logic [AW-1:0] dm_addr  = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic          if_ack, dm_ack, mem_en, mem_we, busy, grant;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    bit            done = 1'b0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(L)) dut (
      .clock_i(clk), .reset_n_i(rst_n),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
      .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
      .dm_ack_o(dm_ack), .dm_rdata_o(dm_rdata),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
      .busy_o(busy), .grant_o(grant)
    );

    // Memory model: data valid only in the capture cycle, noise otherwise
    logic [DW-1:0] mem     [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    int unsigned   rd_cyc  = 0;
    logic [AW-1:0] rd_addr = '0;

    function automatic logic [DW-1:0] mem_get(input logic [AW-1:0] a);
      return mem.exists(a) ? mem[a] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] ref_get(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    always @(negedge clk) begin
      if (mem_en === 1'b1) begin
        if (mem_we === 1'b1) mem[mem_addr] = mem_wdata;
        else begin
          rd_cyc  = cyc + L;
          rd_addr = mem_addr;
        end
      end
    end

    always @(posedge clk) begin
      #1;
      if (cyc == rd_cyc) mem_rdata = mem_get(rd_addr);
      else mem_rdata = $urandom;
    end

    // Reference: grant at cycle t -> strobe at t+1, busy t+1..t+L+2, ack at t+L+2, free at t+L+3
    txn_t          txq[$];
    bit            last_g   = 1'b1;
    int unsigned   free_at  = 0;
    bit            rst_prev = 1'b1;
    logic [DW-1:0] exp_if_rd = '0;
    logic [DW-1:0] exp_dm_rd = '0;

    always @(negedge clk) begin : mon
      txn_t tr;
      txn_t nt;
      bit   has, e_en, e_busy, e_ack;
      has = (txq.size() != 0);
      if (has) tr = txq[0];
      else tr = '{default: '0};
      e_en   = has && (cyc == tr.cyc + 1);
      e_busy = has && (cyc >= tr.cyc + 1) && (cyc <= tr.cyc + L + 2);
      e_ack  = has && (cyc == tr.cyc + L + 2);

      if (rst_prev) chk("reset_mem_bus", gi, {mem_addr, mem_wdata}, 64'd0);
      chk("busy", gi, busy, e_busy);
      chk("mem_strobe", gi, {mem_en, mem_we}, {e_en, e_en & tr.we});
      if (e_en) begin
        chk("mem_addr", gi, mem_addr, tr.addr);
        if (tr.we) chk("mem_wdata", gi, mem_wdata, tr.wdata);
      end
      if (e_busy) chk("grant", gi, grant, tr.owner);
      chk("acks", gi, {dm_ack, if_ack}, e_ack ? (tr.owner ? 2'b10 : 2'b01) : 2'b00);
      if (e_ack) begin
        if (!tr.owner) exp_if_rd = tr.rdata;
        else if (!tr.we) exp_dm_rd = tr.rdata;
        void'(txq.pop_front());
      end
      chk("if_rdata", gi, if_rdata, exp_if_rd);
      chk("dm_rdata", gi, dm_rdata, exp_dm_rd);

      if (rst_n !== 1'b1) begin
        txq.delete();
        last_g    = 1'b1;
        free_at   = cyc + 1;
        exp_if_rd = '0;
        exp_dm_rd = '0;
        rst_prev  = 1'b1;
      end else begin
        rst_prev = 1'b0;
        if (cyc >= free_at && (if_req || dm_req)) begin
          nt.owner = (if_req && dm_req) ? !last_g : dm_req;
          last_g   = nt.owner;
          nt.cyc   = cyc;
          nt.we    = nt.owner && dm_we;
          nt.addr  = nt.owner ? dm_addr : if_addr;
          nt.wdata = dm_wdata;
          if (nt.we) begin
            ref_mem[nt.addr] = nt.wdata;
            nt.rdata = '0;
          end else begin
            nt.rdata = ref_get(nt.addr);
          end
          txq.push_back(nt);
          free_at = cyc + L + 3;
        end
      end
    end

    // Waits for one requester's ack; returns one tick after the edge ending it
    task automatic wait_ack(input bit is_dm, output int unsigned at, output logic [DW-1:0] rd);
      bit ok;
      ok = 1'b0;
      at = 0;
      rd = '0;
      for (int k = 0; k < 100 && !ok; k++) begin
        @(negedge clk);
        if ((is_dm ? dm_ack : if_ack) === 1'b1) begin
          ok = 1'b1;
          at = cyc;
          rd = is_dm ? dm_rdata : if_rdata;
        end
      end
      if (!ok) fail_timeout(is_dm ? "dm_ack_wait" : "if_ack_wait", gi);
      @(posedge clk);
      #1;
    endtask

    task automatic wait_any(output bit owner, output int unsigned at);
      bit ok;
      ok    = 1'b0;
      owner = 1'b0;
      at    = 0;
      for (int k = 0; k < 100 && !ok; k++) begin
        @(negedge clk);
        if (if_ack === 1'b1 || dm_ack === 1'b1) begin
          ok    = 1'b1;
          owner = (dm_ack === 1'b1);
          at    = cyc;
        end
      end
      if (!ok) fail_timeout("any_ack_wait", gi);
      @(posedge clk);
      #1;
    endtask

    // One transaction from an idle arbiter; lat = ack cycle - sample cycle
    task automatic single(input bit is_dm, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, output int unsigned lat,
                          output logic [DW-1:0] rd);
      int unsigned t0, at;
      t0 = cyc;
      if (is_dm) begin
        dm_we = we; dm_addr = a; dm_wdata = wd; dm_req = 1'b1;
      end else begin
        if_addr = a; if_req = 1'b1;
      end
      wait_ack(is_dm, at, rd);
      if_req = 1'b0;
      dm_req = 1'b0;
      lat = at - t0;
    endtask

    task automatic rnd_if(input int n);
      int unsigned gap, at;
      logic [DW-1:0] rd;
      for (int k = 0; k < n; k++) begin
        gap = $urandom_range(0, 3);
        if (gap != 0) begin
          if_req = 1'b0;
          repeat (gap) begin @(posedge clk); #1; end
        end
        if_addr = pool_addr();
        if_req  = 1'b1;
        wait_ack(1'b0, at, rd);
      end
      if_req = 1'b0;
    endtask

    task automatic rnd_dm(input int n);
      int unsigned gap, at;
      logic [DW-1:0] rd;
      for (int k = 0; k < n; k++) begin
        gap = $urandom_range(0, 3);
        if (gap != 0) begin
          dm_req = 1'b0;
          repeat (gap) begin @(posedge clk); #1; end
        end
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = pool_addr();
        dm_wdata = $urandom;
        dm_req   = 1'b1;
        wait_ack(1'b1, at, rd);
      end
      dm_req = 1'b0;
    endtask

    initial begin : stim
      bit            own  [8];
      int unsigned   acyc [8];
      int unsigned   lat, t0;
      logic [DW-1:0] rd;
      bit            o;

      // Reset held two cycles with both requesters pending
      if_req = 1'b1; if_addr = pool_addr();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = pool_addr(); dm_wdata = $urandom;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Sustained contention: strict alternation starting with fetch
      for (int k = 0; k < 8; k++) begin
        wait_any(own[k], acyc[k]);
        if (own[k]) begin
          dm_we = 1'($urandom_range(0, 1)); dm_addr = pool_addr(); dm_wdata = $urandom;
        end else begin
          if_addr = pool_addr();
        end
      end
      if_req = 1'b0;
      dm_req = 1'b0;
      for (int k = 0; k < 8; k++) begin
        chk("contention_owner", gi, 64'(own[k]), 64'(k % 2));
        if (k > 0) chk("ack_spacing", gi, 64'(acyc[k] - acyc[k-1]), 64'(L + 3));
      end
      repeat (L + 4) @(posedge clk);
      #1;

      // Directed fetches, data read, write and read-back
      mem[32'h10] = 32'hDEAD_BEEF; ref_mem[32'h10] = 32'hDEAD_BEEF;
      mem[32'h40] = 32'hCAFE_F00D; ref_mem[32'h40] = 32'hCAFE_F00D;
      single(1'b0, 1'b0, 32'h10, '0, lat, rd);
      chk("fetch_latency", gi, 64'(lat), 64'(L + 2));
      chk("fetch_data", gi, rd, 32'hDEAD_BEEF);
      single(1'b0, 1'b0, 32'h40, '0, lat, rd);
      chk("fetch2_latency", gi, 64'(lat), 64'(L + 2));
      chk("fetch2_data", gi, rd, 32'hCAFE_F00D);
      single(1'b1, 1'b0, 32'h10, '0, lat, rd);
      chk("dread_data", gi, rd, 32'hDEAD_BEEF);
      single(1'b1, 1'b1, 32'h200, 32'h1234_5678, lat, rd);
      chk("dwrite_latency", gi, 64'(lat), 64'(L + 2));
      chk("dwrite_dm_rdata_held", gi, dm_rdata, 32'hDEAD_BEEF);
      chk("dwrite_if_rdata_held", gi, if_rdata, 32'hCAFE_F00D);
      single(1'b1, 1'b0, 32'h200, '0, lat, rd);
      chk("readback_data", gi, rd, 32'h1234_5678);

      // Reset while a data read is waiting on memory
      t0 = cyc;
      dm_we = 1'b0; dm_addr = 32'h300; dm_req = 1'b1;
      repeat (ROFF) begin @(posedge clk); #1; end
      if_addr = 32'h40; if_req = 1'b1; rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0 | 1'b1;
      @(negedge clk);
      chk("midreset_ctl", gi, {busy, grant, if_ack, dm_ack, mem_en}, 5'b0);
      chk("midreset_rdata", gi, {if_rdata, dm_rdata}, 64'd0);
      chk("midreset_cycle", gi, 64'(cyc - t0), 64'(ROFF + 1));
      @(posedge clk);
      #1;
      wait_any(o, lat);
      chk("post_reset_owner", gi, 64'(o), 64'd0);
      if_req = 1'b0;
      wait_ack(1'b1, lat, rd);
      dm_req = 1'b0;
      chk("post_reset_dread", gi, rd, init_val(32'h300));

      // Randomised traffic from both requesters
      fork
        rnd_if(25);
        rnd_dm(25);
      join
      repeat (L + 4) @(posedge clk);
      done = 1'b1;
    end
  end

  initial begin
    for (int k = 0; k < 20000; k++) begin
      @(posedge clk);
      if (g_inst[0].done && g_inst[1].done) break;
    end
    if (!(g_inst[0].done && g_inst[1].done)) fail_timeout("global_run", -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
